// File: rtl/text_term_ctrl.sv
// -----------------------------------------------------------------------------
// text_term_ctrl
//
// Terminal-style write controller for the VGAMod character buffer. Bytes come
// in over a valid/ready handshake; printable characters are written at the
// cursor and a small set of control codes (LF, CR, BS, FF) move the cursor or
// start a full-screen clear. Every buffer write is registered and appears on
// wen/waddr/wdata the cycle after the byte that caused it was accepted.
//
// Optional feature (compile-time macro TERM_LINE_CLEAR_EN):
//   defined   - every row advance (LF or auto-wrap) blanks the new row with
//               COLS writes of 0x20 before the next byte is accepted.
//   undefined - a row advance only moves the cursor.
//
// Ports:
//   CLK         system clock, shared with the VGAMod write port
//   nRST        asynchronous active-low reset
//   in_valid    byte available
//   in_data     byte value
//   in_ready    controller accepts a byte this cycle (combinational)
//   clear_req   single-cycle request for a full-screen clear
//   wen         buffer write enable, one cycle per write
//   waddr       buffer cell address (row*COLS + col)
//   wdata       character code to write
//   cursor_col  current column, 0..COLS-1
//   cursor_row  current row, 0..ROWS-1
//   busy        high while a clear (full or line) sequence is running
// -----------------------------------------------------------------------------
module text_term_ctrl #(
    parameter int COLS           = 100,
    parameter int ROWS           = 30,
    parameter int ADDR_W         = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clear_req,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic [7:0]        cursor_col,
    output logic [7:0]        cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_LEN   = ADDR_W'(COLS);
    localparam logic [7:0]        COL_LAST  = 8'(COLS - 1);
    localparam logic [7:0]        ROW_LAST  = 8'(ROWS - 1);
    localparam logic [7:0]        SPACE     = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef TERM_LINE_CLEAR_EN
        S_LCLEAR,
`endif
        S_CLEAR
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t            state_q, state_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    // Address of column 0 of the current row; stepped by COLS so no
    // multiplier is needed to form row*COLS + col.
    logic [ADDR_W-1:0] base_q, base_d;
    // Write index shared by the full clear (cell number) and line clear
    // (column within the new row).
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              accept;
    logic [ADDR_W-1:0] cell_addr;
    logic [7:0]        next_row;
    logic [ADDR_W-1:0] next_base;

    assign in_ready   = (state_q == S_IDLE) && !clear_req;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != S_IDLE);
    assign wen        = wen_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

    assign cell_addr  = base_q + ADDR_W'(col_q);
    // Row advance wraps from the last row straight back to row 0 (no scroll).
    assign next_row   = (row_q == ROW_LAST) ? 8'd0 : row_q + 8'd1;
    assign next_base  = (row_q == ROW_LAST) ? '0 : base_q + ROW_LEN;

    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wen_d   = 1'b1;
                        waddr_d = cell_addr;
                        wdata_d = in_data;
                        if (col_q == COL_LAST) begin
                            col_d  = 8'd0;
                            row_d  = next_row;
                            base_d = next_base;
`ifdef TERM_LINE_CLEAR_EN
                            state_d = S_LCLEAR;
                            cnt_d   = '0;
`endif
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end else if (in_data == 8'h0A) begin
                        col_d  = 8'd0;
                        row_d  = next_row;
                        base_d = next_base;
`ifdef TERM_LINE_CLEAR_EN
                        state_d = S_LCLEAR;
                        cnt_d   = '0;
`endif
                    end else if (in_data == 8'h0D) begin
                        col_d = 8'd0;
                    end else if (in_data == 8'h08) begin
                        // Backspace never crosses back onto the previous row.
                        if (col_q != 8'd0) begin
                            col_d   = col_q - 8'd1;
                            wen_d   = 1'b1;
                            waddr_d = cell_addr - ADDR_W'(1);
                            wdata_d = SPACE;
                        end
                    end else if (in_data == 8'h0C) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end
                    // Any other code is consumed without effect.
                end
            end

            S_CLEAR: begin
                wen_d   = 1'b1;
                waddr_d = cnt_q;
                wdata_d = SPACE;
                if (cnt_q == LAST_CELL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    col_d   = 8'd0;
                    row_d   = 8'd0;
                    base_d  = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

`ifdef TERM_LINE_CLEAR_EN
            S_LCLEAR: begin
                // base_q already points at the new row.
                wen_d   = 1'b1;
                waddr_d = base_q + cnt_q;
                wdata_d = SPACE;
                if (cnt_q == ADDR_W'(COLS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RST_STATE;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            base_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
